// File: rtl/hist_frame_sequencer.sv
// rtl/hist_frame_sequencer.sv - frame sequencer: fetch packed pixels, bin them, drain counters to histogram memory
// Walks N=(dim>>2)*dim pixel words, accumulates 4 lanes per word, then writes and clears bins 0..hist_bins.
module hist_frame_sequencer #(
  parameter int ADDR_W = 14,
  parameter int NBINS  = 64,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        dim,
  input  logic [5:0]        hist_bins,
  output logic              busy,
  output logic              done,
  output logic              pixel_rd_en,
  output logic [ADDR_W-1:0] pixel_address,
  input  logic [31:0]       pixel_data,
  output logic              writeEnable_hist,
  output logic [5:0]        addr_hist,
  output logic [31:0]       datain_hist
);

  localparam int NW   = 18;
  localparam int FL_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [NW-1:0]     nwords_q;
  logic [NW-1:0]     nwords_d;
  logic [NW-1:0]     dim_ext;
  logic [5:0]        hb_q;
  logic [NW-1:0]     idx_q;
  logic              rd_en_q;
  logic [FL_W-1:0]   flush_q;
  logic              we_q;
  logic [5:0]        haddr_q;
  logic              busy_q;
  logic              done_q;
  logic [RD_LAT-1:0] vld_q;
  logic              data_vld;
  logic [CNT_W-1:0]  cnt_q [NBINS];
  logic [2:0]        inc [NBINS];
  logic [5:0]        lane_bin [4];
  logic              unused_pix;

  assign dim_ext  = NW'(dim);
  assign nwords_d = (dim_ext >> 2) * dim_ext;
  assign data_vld = vld_q[RD_LAT-1];

  assign busy             = busy_q;
  assign done             = done_q;
  assign pixel_rd_en      = rd_en_q;
  assign pixel_address    = ADDR_W'(idx_q);
  assign writeEnable_hist = we_q;
  assign addr_hist        = haddr_q;
  assign datain_hist      = we_q ? 32'(cnt_q[haddr_q]) : 32'd0;
  assign unused_pix       = ^{pixel_data[25:24], pixel_data[17:16], pixel_data[9:8], pixel_data[1:0]};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Lanes landing in the same bin merge into one increment of 0..4.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_bin[l] = pixel_data[8*l+2 +: 6];
    end
    for (int i = 0; i < NBINS; i++) begin
      inc[i] = 3'd0;
      for (int l = 0; l < 4; l++) begin
        if (data_vld && lane_bin[l] == 6'(i)) begin
          inc[i] = inc[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Accumulation and drain never overlap: the last word lands before WRITE starts.
  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE && start)) begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (we_q) begin
      cnt_q[haddr_q] <= '0;
    end else if (data_vld) begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_q[i] <= sat_add(cnt_q[i], inc[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      nwords_q <= '0;
      hb_q     <= '0;
      idx_q    <= '0;
      rd_en_q  <= 1'b0;
      flush_q  <= '0;
      we_q     <= 1'b0;
      haddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            nwords_q <= nwords_d;
            hb_q     <= hist_bins;
            busy_q   <= 1'b1;
            if (nwords_d == '0) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              haddr_q <= '0;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
              idx_q   <= '0;
            end
          end
        end
        S_FETCH: begin
          if (idx_q == nwords_q - NW'(1)) begin
            rd_en_q <= 1'b0;
            idx_q   <= '0;
            flush_q <= '0;
            state_q <= S_FLUSH;
          end else begin
            idx_q <= idx_q + NW'(1);
          end
        end
        S_FLUSH: begin
          if (flush_q == FL_W'(RD_LAT - 1)) begin
            state_q <= S_WRITE;
            we_q    <= 1'b1;
            haddr_q <= '0;
          end else begin
            flush_q <= flush_q + FL_W'(1);
          end
        end
        S_WRITE: begin
          if (haddr_q == hb_q) begin
            we_q    <= 1'b0;
            haddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            haddr_q <= haddr_q + 6'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_frame_sequencer.sv
// tb/tb_hist_frame_sequencer.sv - scoreboard bench for hist_frame_sequencer
// Stimulus pushes expected reads/writes/done cycles; a negedge monitor pops and compares.
module tb_hist_frame_sequencer;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  dim = '0;
  logic [5:0]  hist_bins = '0;
  logic        busy, done, pixel_rd_en, writeEnable_hist;
  logic [13:0] pixel_address;
  logic [31:0] pixel_data = '0;
  logic [5:0]  addr_hist;
  logic [31:0] datain_hist;

  logic [31:0] mem [16384];
  int          exp_bins [64];
  int          rdq [$];
  int          wq_addr [$];
  longint      wq_data [$];
  int          doneq [$];
  int          done_seen = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          s0;

  hist_frame_sequencer #(.ADDR_W(14), .NBINS(64), .CNT_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .dim(dim), .hist_bins(hist_bins),
    .busy(busy), .done(done), .pixel_rd_en(pixel_rd_en), .pixel_address(pixel_address),
    .pixel_data(pixel_data), .writeEnable_hist(writeEnable_hist), .addr_hist(addr_hist),
    .datain_hist(datain_hist)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pixel_rd_en) pixel_data <= mem[pixel_address];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_rd_en) begin
        if (rdq.size() == 0) chk("read_unexpected_addr", pixel_address, -1);
        else chk("read_addr", pixel_address, rdq.pop_front());
      end
      if (writeEnable_hist) begin
        if (wq_addr.size() == 0) chk("write_unexpected_addr", addr_hist, -1);
        else begin
          chk("write_addr", addr_hist, wq_addr.pop_front());
          chk("write_data", datain_hist, wq_data.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (doneq.size() == 0) chk("done_unexpected_cycle", cyc, -1);
        else chk("done_cycle", cyc, doneq.pop_front());
      end
    end
  end

  task automatic clear_bins();
    for (int i = 0; i < 64; i++) exp_bins[i] = 0;
  endtask

  task automatic launch(input int d, input int hb, output int s);
    int n;
    n = (d / 4) * d;
    for (int i = 0; i < n; i++) rdq.push_back(i);
    for (int k = 0; k <= hb; k++) begin
      wq_addr.push_back(k);
      wq_data.push_back(longint'(exp_bins[k]));
    end
    @(posedge clk); #1;
    start = 1'b1;
    dim = 9'(d);
    hist_bins = 6'(hb);
    s = cyc;
    doneq.push_back(n > 0 ? s + n + RD_LAT + hb + 2 : s + hb + 2);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int i;
    i = 0;
    while (done_seen < target && i < limit) begin
      @(posedge clk);
      i++;
    end
    chk("done_count", done_seen, target);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, pixel_rd_en, 0);
    chk({tag, "_pix_addr"}, pixel_address, 0);
    chk({tag, "_we"}, writeEnable_hist, 0);
    chk({tag, "_addr_hist"}, addr_hist, 0);
    chk({tag, "_datain"}, datain_hist, 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // 1: all-zero 4x4 frame
    clear_bins();
    exp_bins[0] = 16;
    launch(4, 63, s0);
    chk("busy_frame", busy, 1);
    wait_done(1, 200);

    // 2: mixed bins
    mem[0] = 32'h100C0804; mem[1] = 32'h04040404; mem[2] = 32'hFFFFFFFF; mem[3] = 32'h0;
    clear_bins();
    exp_bins[0] = 4; exp_bins[1] = 5; exp_bins[2] = 1; exp_bins[3] = 1; exp_bins[4] = 1; exp_bins[63] = 4;
    launch(4, 63, s0);
    wait_done(2, 200);

    // 3: saturation at 65535
    for (int i = 0; i < 16384; i++) mem[i] = 32'h80808080;
    clear_bins();
    exp_bins[32] = 65535;
    launch(256, 33, s0);
    wait_done(3, 20000);

    // 4: reset mid-FETCH, then a clean frame
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFFFFFF;
    clear_bins();
    launch(8, 63, s0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_at_addr5", pixel_address, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rdq.delete(); wq_addr.delete(); wq_data.delete(); doneq.delete();
    check_idle_outputs("abort");
    @(posedge clk); #1;
    chk("abort_we_in_reset", writeEnable_hist, 0);
    rst = 1'b0;
    chk("abort_no_done", done_seen, 3);
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    clear_bins();
    exp_bins[0] = 16;
    launch(4, 63, s0);
    wait_done(4, 200);

    // 5: start while busy and start coincident with done
    clear_bins();
    exp_bins[0] = 16;
    launch(4, 3, s0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, 50);
    repeat (20) @(posedge clk);
    #1;
    chk("single_done", done_seen, 5);
    chk("idle_after_done", busy, 0);

    // 6: dim=0 goes straight to WRITE
    clear_bins();
    launch(0, 3, s0);
    wait_done(6, 50);

    chk("rdq_empty", rdq.size(), 0);
    chk("wq_empty", wq_addr.size(), 0);
    chk("doneq_empty", doneq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
